// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// It retires one bit per cycle: shift-add multiply and restoring divide on operand magnitudes.
module mult_div_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         cancel,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [N-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            bzero_q, bzero_d;
    logic [N-1:0]    m_q, m_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            is_signed;
    logic            in_sa, in_sb;
    logic [N-1:0]    abs_a, abs_b;
    logic [N:0]      msum;
    logic [2*N-1:0]  mult_next;
    logic [N:0]      rem_sh;
    logic [N+1:0]    trial;
    logic [2*N-1:0]  div_next;
    logic [2*N-1:0]  prod_fix;
    logic [N-1:0]    quo_fix, rem_fix;

    // Signed operands are reduced to magnitudes; the signs are re-applied in FINISH.
    always_comb begin
        is_signed = ~op[0];
        in_sa     = is_signed & inA[N-1];
        in_sb     = is_signed & inB[N-1];
        abs_a     = in_sa ? (~inA + 1'b1) : inA;
        abs_b     = in_sb ? (~inB + 1'b1) : inB;
    end

    always_comb begin
        msum      = {1'b0, acc_q[2*N-1:N]} + {1'b0, m_q};
        mult_next = acc_q[0] ? {msum, acc_q[N-1:1]} : {1'b0, acc_q[2*N-1:1]};

        rem_sh    = {acc_q[2*N-1:N], acc_q[N-1]};
        trial     = {1'b0, rem_sh} - {2'b00, m_q};
        div_next  = trial[N+1] ? {rem_sh[N-1:0], acc_q[N-2:0], 1'b0}
                               : {trial[N-1:0], acc_q[N-2:0], 1'b1};

        prod_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = (sign_a_q ^ sign_b_q) ? (~acc_q[N-1:0] + 1'b1) : acc_q[N-1:0];
        // With a zero divisor the remainder ends up holding |inA|, so this also restores inA.
        rem_fix   = sign_a_q ? (~acc_q[2*N-1:N] + 1'b1) : acc_q[2*N-1:N];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (cancel)                       state_d = IDLE;
                else if (cnt_q == CW'(N - 1))     state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bzero_d  = bzero_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hi_wen) hi_d = wd;
                if (lo_wen) lo_d = wd;
                if (start) begin
                    is_div_d = op[1];
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    bzero_d  = op[1] & (inB == '0);
                    m_d      = op[1] ? abs_b : abs_a;
                    acc_d    = {{N{1'b0}}, (op[1] ? abs_a : abs_b)};
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (!cancel) begin
                    acc_d = is_div_q ? div_next : mult_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                if (!cancel) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*N-1:N];
                        lo_d = prod_fix[N-1:0];
                    end else if (bzero_q) begin
                        hi_d  = rem_fix;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bzero_q  <= bzero_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        div_by_zero = dbz_q;
        hi          = hi_q;
        lo          = lo_q;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit: the parametrised, multi-cycle companion to the single-cycle ALU.
- Executes MIPS mult, multu, div and divu over N-bit operands, one bit per cycle, and holds the results in HI/LO registers.
- Sits beside the ALU in the execute stage. The pipeline control stalls on busy and reads HI/LO for mfhi/mflo.
- Also serves mthi/mtlo through direct register writes.

Parameters:
- N, 32, operand width; hi and lo are each N bits; N >= 4.

Ports:
- clock  input  1  single clock; all state changes on the posedge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  0=mult (signed), 1=multu, 2=div (signed), 3=divu; sampled with start.
- inA  input  N  multiplicand or dividend; sampled with start.
- inB  input  N  multiplier or divisor; sampled with start.
- cancel  input  1  synchronous abort of a running operation.
- hi_wen  input  1  mthi: write wd into hi; honoured only in IDLE.
- lo_wen  input  1  mtlo: write wd into lo; honoured only in IDLE.
- wd  input  N  write data for hi_wen/lo_wen.
- busy  output  1  high while in RUN or FINISH.
- done  output  1  one-cycle pulse; hi/lo hold the new result.
- div_by_zero  output  1  valid with done; 1 when a div/divu had inB=0.
- hi  output  N  HI register (mult: upper product; div: remainder).
- lo  output  N  LO register (mult: lower product; div: quotient).

Behaviour:
- Reset (reset==0, async): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; internal operand, accumulator and counter registers = 0. Reset mid-operation discards the operation.
- Outputs are registered. done and div_by_zero default to 0 every edge unless set as below.
- State IDLE:
  - hi_wen/lo_wen write wd to hi/lo at the edge.
  - start=1 at edge 0: latch op; signed ops latch magnitudes |inA|, |inB| plus the sign bits; clear the 2N-bit accumulator; count=0; go to RUN; busy=1 after edge 0.
  - A write and start on the same edge: the write applies; the later result overwrites it.
- State RUN, one iteration per edge, count 0..N-1:
  - mult: shift-add. If the current multiplier LSB is 1, add the multiplicand into the upper accumulator half, then shift right one bit.
  - div: restoring division. Shift the remainder:dividend left one bit; trial-subtract the divisor from the upper N+1 bits; if non-negative keep the result and set quotient bit 1, else quotient bit 0.
  - After the N-th iteration (edge N) go to FINISH.
- State FINISH, at edge N+1:
  - Apply sign fix-up:
    - mult: negate the 2N-bit product if signA^signB.
    - div: negate the quotient if signA^signB; negate the remainder if signA.
  - Write hi/lo; done=1; state=IDLE; busy=0.
  - Total latency: start edge 0 to done at edge N+1 (33 for N=32).
- Divide by zero (inB=0, op 2 or 3):
  - Same latency; no sign fix-up.
  - lo = all ones, hi = inA as given (unsigned bit pattern), div_by_zero=1 with done.
- Signed overflow case: div of most-negative by -1 gives lo = most-negative (2^(N-1) pattern), hi=0, div_by_zero=0.
- mult of most-negative by most-negative gives the correct positive 2N-bit product.
- cancel=1 in RUN or FINISH:
  - Next edge returns to IDLE; busy=0; done stays 0.
  - hi/lo keep their previous values.
  - cancel has priority over the FINISH update. cancel in IDLE has no effect.
- start while busy is ignored, with no queuing. hi_wen/lo_wen while busy are ignored. hi/lo are stable throughout RUN.
- A new start may be accepted on the edge after done (done deasserts that same edge).
- op, inA and inB may change freely after the start edge.

Test Plan:
- Reset then multu 0xFFFFFFFF*0xFFFFFFFF (N=32) -> busy edges 1..33; done pulse after edge 33; hi=0xFFFFFFFE, lo=0x00000001.
- mult 0xFFFFFFFD (-3) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then divu 100/7 -> lo=14, hi=2.
- div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- divu 0x1234 / 0 -> after 33 edges lo=0xFFFFFFFF, hi=0x00001234, div_by_zero=1 for one cycle. The next operation's done shows div_by_zero=0.
- mthi 0xAAAA5555, then start multu 3*5 and pulse start again plus hi_wen at edge 10 -> the second start and the write are ignored; the final hi=0, lo=15.
- Start mult, cancel at edge 5 -> busy=0 from edge 6, no done, hi/lo unchanged. Start again and drop reset at edge 12 -> all outputs 0 immediately, without waiting for a clock edge.
